// File: rtl/wb_arbiter_2m_if.sv
// Wishbone bus bundle: master drives the request side, slave drives ack and read data.
interface wishbone_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cycle;
    logic              strobe;
    logic              write_enable;
    logic [DW/8-1:0]   select;
    logic [AW-1:0]     address;
    logic [DW-1:0]     data_in;
    logic [DW-1:0]     data_out;
    logic              ack;

    modport master (
        output cycle, strobe, write_enable, select, address, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, write_enable, select, address, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with a watchdog that force-acks a stalled slave.
module wb_arbiter_2m #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic       clk,
    input  logic       reset,
    wishbone_if.slave  m0,
    wishbone_if.slave  m1,
    wishbone_if.master s,
    output logic [1:0] grant,
    output logic       timeout_err
);
    localparam int            WW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nxt;
    logic          last_owner;   // 0 = m0 served last, 1 = m1
    logic [WW-1:0] wdog;
    logic          own_req, forced_ack, real_ack;
    logic [31:0]   rsp_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0.cycle && m1.cycle) state_nxt = last_owner ? OWN0 : OWN1;
                else if (m0.cycle)        state_nxt = OWN0;
                else if (m1.cycle)        state_nxt = OWN1;
            end
            OWN0:    if (!m0.cycle) state_nxt = m1.cycle ? OWN1 : IDLE;
            OWN1:    if (!m1.cycle) state_nxt = m0.cycle ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner's request goes straight to the slave; responses straight back.
    always_comb begin
        s.cycle        = 1'b0;
        s.strobe       = 1'b0;
        s.write_enable = 1'b0;
        s.select       = '0;
        s.address      = '0;
        s.data_in      = '0;
        m0.ack         = 1'b0;
        m0.data_out    = '0;
        m1.ack         = 1'b0;
        m1.data_out    = '0;
        own_req        = 1'b0;
        case (state)
            OWN0: begin
                s.cycle        = m0.cycle;
                s.strobe       = m0.strobe;
                s.write_enable = m0.write_enable;
                s.select       = m0.select;
                s.address      = m0.address;
                s.data_in      = m0.data_in;
                own_req        = m0.cycle & m0.strobe;
            end
            OWN1: begin
                s.cycle        = m1.cycle;
                s.strobe       = m1.strobe;
                s.write_enable = m1.write_enable;
                s.select       = m1.select;
                s.address      = m1.address;
                s.data_in      = m1.data_in;
                own_req        = m1.cycle & m1.strobe;
            end
            default: ;
        endcase
        // A real ack in the same cycle as the watchdog expiry takes precedence.
        real_ack   = own_req & s.ack;
        forced_ack = own_req & (wdog == WD_MAX) & ~s.ack;
        rsp_data   = forced_ack ? ERR_DATA : s.data_out;
        if (state == OWN0) begin
            m0.ack      = real_ack | forced_ack;
            m0.data_out = rsp_data;
        end
        if (state == OWN1) begin
            m1.ack      = real_ack | forced_ack;
            m1.data_out = rsp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= forced_ack;
            if (state == OWN0 && state_nxt != OWN0) last_owner <= 1'b0;
            if (state == OWN1 && state_nxt != OWN1) last_owner <= 1'b1;
            if (state_nxt != state || s.ack || !own_req || forced_ack)
                wdog <= '0;
            else if (wdog != WD_MAX)
                wdog <= wdog + 1'b1;
        end
    end

    assign grant = {state == OWN1, state == OWN0};
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: RAM slave model, directed scenarios, then random two-master traffic.
module tb_wb_arbiter_2m;
    logic        clk, rst;
    logic [1:0]  grant;
    logic        timeout_err;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_wd  [2];
    logic        m_ack [2];
    logic [31:0] m_rdat[2];

    logic        s_ack_r, stray, no_ack;
    logic [31:0] s_rd;
    logic [31:0] mem     [64];
    logic        mem_v   [64];
    logic [31:0] ref_mem [64];

    int n_tests = 0, n_fail = 0, terr_cnt = 0;

    wishbone_if m0_if ();
    wishbone_if m1_if ();
    wishbone_if s_if ();

    assign m0_if.cycle = m_cyc[0];  assign m1_if.cycle = m_cyc[1];
    assign m0_if.strobe = m_stb[0]; assign m1_if.strobe = m_stb[1];
    assign m0_if.write_enable = m_we[0]; assign m1_if.write_enable = m_we[1];
    assign m0_if.select = m_sel[0]; assign m1_if.select = m_sel[1];
    assign m0_if.address = m_adr[0]; assign m1_if.address = m_adr[1];
    assign m0_if.data_in = m_wd[0]; assign m1_if.data_in = m_wd[1];
    assign m_ack[0] = m0_if.ack;    assign m_ack[1] = m1_if.ack;
    assign m_rdat[0] = m0_if.data_out; assign m_rdat[1] = m1_if.data_out;
    assign s_if.ack = s_ack_r | stray;
    assign s_if.data_out = s_rd;

    wb_arbiter_2m #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0001_0203) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // RAM slave: single-cycle ack pulse one edge after a strobe is seen.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack_r <= 1'b0;
        end else if (s_if.cycle && s_if.strobe && !s_ack_r && !no_ack) begin
            s_ack_r <= 1'b1;
            s_rd    <= mem_v[s_if.address[7:2]] ? mem[s_if.address[7:2]] : init_word(int'(s_if.address[7:2]));
            if (s_if.write_enable) begin
                mem[s_if.address[7:2]]   <= merge(mem_v[s_if.address[7:2]] ? mem[s_if.address[7:2]]
                                                  : init_word(int'(s_if.address[7:2])), s_if.data_in, s_if.select);
                mem_v[s_if.address[7:2]] <= 1'b1;
            end
        end else begin
            s_ack_r <= 1'b0;
        end
    end

    always @(negedge clk) if (!rst && timeout_err) terr_cnt++;

    task automatic clear_masters();
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0; m_sel[m] = 4'hF; m_adr[m] = '0; m_wd[m] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1; stray = 0; no_ack = 0;
        clear_masters();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
    endtask

    // Drives one transfer from posedge+1; returns at posedge+1 after the ack.
    task automatic xfer(input int m, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, input bit keep,
                        output logic [31:0] rd, output bit ok, output int waits);
        m_cyc[m] = 1; m_stb[m] = 1; m_we[m] = we; m_adr[m] = adr; m_sel[m] = sel; m_wd[m] = wd;
        ok = 0; rd = '0; waits = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            waits++;
            if (m_ack[m]) begin ok = 1; rd = m_rdat[m]; break; end
        end
        @(posedge clk); #1;
        m_stb[m] = 0; m_we[m] = 0;
        if (!keep) m_cyc[m] = 0;
    endtask

    task automatic test_reset();
        rst = 1; stray = 0; no_ack = 0;
        clear_masters();
        m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
        #2 @(negedge clk);
        n_tests++;
        if ({grant, s_if.cycle, s_if.strobe, s_if.write_enable, m_ack[0], m_ack[1], timeout_err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b scyc=%b sstb=%b swe=%b ack0=%b ack1=%b terr=%b exp all 0",
                     grant, s_if.cycle, s_if.strobe, s_if.write_enable, m_ack[0], m_ack[1], timeout_err);
        end
        n_tests++;
        if ({m_rdat[0], m_rdat[1], s_if.address, s_if.select} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data: got d0=%h d1=%h adr=%h sel=%h exp 0", m_rdat[0], m_rdat[1], s_if.address, s_if.select);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        bit m1_acked = 0, got = 0;
        logic [31:0] rd = '0;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h10; m_sel[0] = 4'hF;
        @(negedge clk);
        n_tests++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL single_arb_lat: got %b exp 00", grant); end
        @(negedge clk);
        n_tests++;
        if (grant !== 2'b01 || s_if.address !== 32'h10 || s_if.cycle !== 1'b1) begin
            n_fail++; $display("FAIL single_route: got grant=%b adr=%h cyc=%b exp 01/00000010/1", grant, s_if.address, s_if.cycle);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_ack[1]) m1_acked = 1;
            if (m_ack[0]) begin got = 1; rd = m_rdat[0]; end
            else @(negedge clk);
        end
        n_tests++;
        if (!got || rd !== ref_mem[4]) begin n_fail++; $display("FAIL single_data: got ok=%0d %h exp %h", got, rd, ref_mem[4]); end
        n_tests++;
        if (m1_acked) begin n_fail++; $display("FAIL single_m1_ack: got 1 exp 0"); end
        @(posedge clk); #1;
        clear_masters();
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [31:0] rd0, rd1;
        bit ok0, ok1;
        int w0, w1;
        logic [13:0] gseq, gexp;
        do_reset();
        // Three rounds: fresh after reset, idle after m1 served, idle after m0 served.
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                xfer(0, 0, 32'h8, 4'hF, '0, 0, rd0, ok0, w0);
                repeat (2) @(posedge clk); #1;
            end
            gseq = '0;
            fork
                xfer(0, 0, 32'h0, 4'hF, '0, 0, rd0, ok0, w0);
                xfer(1, 0, 32'h40, 4'hF, '0, 0, rd1, ok1, w1);
                for (int k = 0; k < 7; k++) begin @(negedge clk); gseq = {gseq[11:0], grant}; end
            join
            gexp = (r == 2) ? 14'b00_10_10_10_01_01_01 : 14'b00_01_01_01_10_10_10;
            n_tests++;
            if (gseq !== gexp) begin n_fail++; $display("FAIL rr_grant_seq%0d: got %b exp %b", r, gseq, gexp); end
            n_tests++;
            if (!ok0 || !ok1 || rd0 !== ref_mem[0] || rd1 !== ref_mem[16]) begin
                n_fail++; $display("FAIL rr_data%0d: got %h %h exp %h %h", r, rd0, rd1, ref_mem[0], ref_mem[16]);
            end
            n_tests++;
            if ((r == 2 && (w1 != 3 || w0 != 6)) || (r != 2 && (w0 != 3 || w1 != 6))) begin
                n_fail++; $display("FAIL rr_latency%0d: got w0=%0d w1=%0d", r, w0, w1);
            end
            repeat (2) @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd0, rd1;
        bit ok0, ok1;
        int w0, w1;
        do_reset();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    xfer(0, 0, 32'(4 * (k + 1)), 4'hF, '0, k < 2, rd0, ok0, w0);
                    n_tests++;
                    if (!ok0 || rd0 !== ref_mem[k + 1] || (k < 2 && grant !== 2'b01)) begin
                        n_fail++; $display("FAIL hold_read%0d: got ok=%0d %h grant=%b exp %h 01", k, ok0, rd0, grant, ref_mem[k + 1]);
                    end
                    if (k == 0) begin
                        stray = 1;
                        @(negedge clk);
                        n_tests++;
                        if (m_ack[0] !== 1'b0 || grant !== 2'b01) begin
                            n_fail++; $display("FAIL stray_ack: got ack=%b grant=%b exp 0 01", m_ack[0], grant);
                        end
                        @(posedge clk); #1 stray = 0;
                    end
                end
                @(negedge clk);
                n_tests++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL hold_release_pre: got %b exp 01", grant); end
                @(negedge clk);
                n_tests++;
                if (grant !== 2'b10) begin n_fail++; $display("FAIL hold_handover: got %b exp 10", grant); end
            end
            begin
                @(posedge clk); #1;
                xfer(1, 0, 32'h44, 4'hF, '0, 0, rd1, ok1, w1);
            end
        join
        n_tests++;
        if (!ok1 || rd1 !== ref_mem[17]) begin n_fail++; $display("FAIL hold_m1_data: got %h exp %h", rd1, ref_mem[17]); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        bit ok;
        int w, t0;
        no_ack = 1;
        t0 = terr_cnt;
        xfer(1, 0, 32'h30, 4'hF, '0, 0, rd, ok, w);
        n_tests++;
        // one arbitration cycle, then the 16th strobe cycle carries the forced ack
        if (!ok || w != 17 || rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL timeout_ack: got ok=%0d waits=%0d data=%h exp 1 17 deadbeef", ok, w, rd);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (terr_cnt - t0 != 1) begin n_fail++; $display("FAIL timeout_err_pulse: got %0d pulses exp 1", terr_cnt - t0); end
        no_ack = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, exp;
        bit ok, got = 0;
        int w;
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_sel[1] = 4'b0010; m_adr[1] = 32'h24; m_wd[1] = 32'h0000AB00;
        repeat (2) @(negedge clk);
        n_tests++;
        if (grant !== 2'b10 || s_if.select !== 4'b0010 || s_if.data_in !== 32'h0000AB00 ||
            s_if.address !== 32'h24 || s_if.write_enable !== 1'b1) begin
            n_fail++; $display("FAIL bw_route: got grant=%b sel=%b d=%h adr=%h we=%b", grant, s_if.select,
                               s_if.data_in, s_if.address, s_if.write_enable);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_ack[1]) got = 1; else @(negedge clk);
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL bw_ack: got no ack exp ack"); end
        @(posedge clk); #1;
        clear_masters();
        exp = {ref_mem[9][31:16], 8'hAB, ref_mem[9][7:0]};
        ref_mem[9] = exp;
        @(posedge clk); #1;
        xfer(0, 0, 32'h24, 4'hF, '0, 0, rd, ok, w);
        n_tests++;
        if (!ok || rd !== exp) begin n_fail++; $display("FAIL bw_readback: got %h exp %h", rd, exp); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        do_reset();
        no_ack = 1;
        m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 32'h28;
        repeat (2) @(negedge clk);
        n_tests++;
        if (grant !== 2'b10 || s_if.cycle !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b exp 10", grant); end
        #2 rst = 1;
        #1;
        n_tests++;
        if (grant !== 2'b00 || s_if.cycle !== 1'b0 || m_ack[0] !== 1'b0 || m_ack[1] !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got grant=%b scyc=%b ack=%b%b exp 00 0 00", grant, s_if.cycle, m_ack[0], m_ack[1]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 0; no_ack = 0;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h2C;
        @(negedge clk);
        n_tests++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL rmid_after: got %b exp 01", grant); end
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_ack[0]) got = 1; else @(negedge clk);
        end
        n_tests++;
        if (!got || m_rdat[0] !== ref_mem[11]) begin n_fail++; $display("FAIL rmid_data: got %h exp %h", m_rdat[0], ref_mem[11]); end
        @(posedge clk); #1;
        clear_masters();
        repeat (2) @(posedge clk); #1;
    endtask

    // Random master: own word range so ordering between masters never matters.
    task automatic rand_master(input int m, input int n);
        logic [31:0] rd, wd;
        logic [3:0]  sel;
        bit ok, we, keep, held = 0;
        int w, word;
        for (int i = 0; i < n; i++) begin
            if (!held) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            word = 32 + m * 8 + int'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            sel  = we ? 4'($urandom_range(1, 15)) : 4'hF;
            wd   = $urandom;
            keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
            xfer(m, we, 32'(word * 4), sel, wd, keep, rd, ok, w);
            held = keep;
            n_tests++;
            if (!ok || (!we && rd !== ref_mem[word])) begin
                n_fail++; $display("FAIL rand_m%0d_xfer%0d: got ok=%0d %h exp %h", m, i, ok, rd, ref_mem[word]);
            end
            if (we) ref_mem[word] = merge(ref_mem[word], wd, sel);
        end
    endtask

    task automatic test_random();
        bit done = 0;
        int t0;
        do_reset();
        t0 = terr_cnt;
        fork
            begin
                fork
                    rand_master(0, 25);
                    rand_master(1, 25);
                join
                done = 1;
            end
            begin
                logic [1:0] pg, last, exp;
                logic pc0, pc1;
                bit have = 0;
                last = 2'b10;
                while (!done) begin
                    @(negedge clk);
                    if (have) begin
                        // owner keeps the bus while its cycle is high; otherwise the waiting
                        // master gets it directly; from idle the one not served last wins a tie
                        if (pg == 2'b01)      exp = pc0 ? 2'b01 : (pc1 ? 2'b10 : 2'b00);
                        else if (pg == 2'b10) exp = pc1 ? 2'b10 : (pc0 ? 2'b01 : 2'b00);
                        else if (pc0 && pc1)  exp = (last == 2'b01) ? 2'b10 : 2'b01;
                        else                  exp = pc0 ? 2'b01 : (pc1 ? 2'b10 : 2'b00);
                        n_tests++;
                        if (grant !== exp) begin n_fail++; $display("FAIL rand_grant: got %b exp %b", grant, exp); end
                    end
                    pg = grant; pc0 = m_cyc[0]; pc1 = m_cyc[1];
                    if (grant != 2'b00) last = grant;
                    have = 1;
                end
            end
        join
        n_tests++;
        if (terr_cnt != t0) begin n_fail++; $display("FAIL rand_no_timeout: got %0d pulses exp 0", terr_cnt - t0); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_v[i] = 1'b0; mem[i] = '0; ref_mem[i] = init_word(i);
        end
        s_rd = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold();
        test_timeout();
        test_byte_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
